// File: rtl/cpu_mc.sv
// cpu_mc: parametrised multicycle 32-bit core on a single request/ready memory bus.
// Instruction forms: 0 = ALU/load/store with imm16, 1 = same with register rb,
// 2 = conditional branch (optional link), 3 = undefined.
// Build option: define CPU_TRAP_EN to make form 3 trap to TRAP_VEC with a
// return address in R[REG_COUNT-2]; otherwise form 3 executes as a NOP.
// Each memory state (FETCH, LOAD, STORE) spends its first cycle with mem_req low
// while the address registers settle, then raises mem_req and holds every bus
// output until the mem_ready edge. This gives 3 cycles per ALU/branch
// instruction and 5 per load/store with a zero-wait memory.
module cpu_mc #(
    parameter int          ADDR_W    = 30,
    parameter int          REG_COUNT = 16,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned TRAP_VEC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire
);
    localparam int RSEL_W = $clog2(REG_COUNT);
    localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [RSEL_W-1:0] L_LINK_REG = RSEL_W'(REG_COUNT - 1);

    typedef enum logic [1:0] {FETCH, EXEC, LOAD, STORE} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [31:0]       r_ir, w_ir_next;
    logic              r_mem_req, w_mem_req_next;
    logic              r_mem_we, w_mem_we_next;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [31:0]       r_mem_wdata, w_mem_wdata_next;
    logic              r_retire, w_retire_next;

    // Register file: not reset, combinational read, one write port.
    logic [31:0]       r_regs [REG_COUNT];
    logic              w_rf_we;
    logic [RSEL_W-1:0] w_rf_waddr;
    logic [31:0]       w_rf_wdata;

    // Decode fields; register selects use the low RSEL_W bits of each 4-bit field.
    logic [1:0]        w_form;
    logic [RSEL_W-1:0] w_rd, w_ra, w_rb;
    logic [3:0]        w_aluop;
    logic [31:0]       w_imm16, w_imm24;
    logic [31:0]       w_rd_val, w_ra_val, w_rb_val;
    logic [31:0]       w_alu_a, w_alu_b, w_alu_out;
    logic [ADDR_W-1:0] w_pc_inc, w_br_target;
    logic [31:0]       w_link;
    logic              w_br_take;

    assign w_form      = r_ir[31:30];
    assign w_rd        = r_ir[24 +: RSEL_W];
    assign w_aluop     = r_ir[23:20];
    assign w_ra        = r_ir[16 +: RSEL_W];
    assign w_rb        = r_ir[12 +: RSEL_W];
    assign w_imm16     = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_imm24     = {{8{r_ir[23]}}, r_ir[23:0]};
    assign w_rd_val    = r_regs[w_rd];
    assign w_ra_val    = r_regs[w_ra];
    assign w_rb_val    = r_regs[w_rb];
    assign w_alu_a     = w_ra_val;
    assign w_alu_b     = (w_form == 2'b01) ? w_rb_val : w_imm16;
    // pc arithmetic wraps modulo 2^ADDR_W; the branch target uses the branch's own pc.
    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_br_target = ADDR_W'(32'(r_pc) + w_imm24);
    assign w_link      = 32'({w_pc_inc, 2'b00});
    // Condition reads R[rd] before any link write lands on this edge.
    assign w_br_take   = r_ir[29] ? (w_rd_val == '0) : (w_rd_val != '0);

`ifdef CPU_TRAP_EN
    localparam logic [ADDR_W-1:0] L_TRAP_VEC = ADDR_W'(TRAP_VEC);
    localparam logic [RSEL_W-1:0] L_TRAP_REG = RSEL_W'(REG_COUNT - 2);
`else
    // Keeps TRAP_VEC referenced when traps are compiled out.
    logic w_unused_trap;
    assign w_unused_trap = ^TRAP_VEC;
`endif

    // ALU: op 0-9 as listed, any other op passes operand b through (move).
    always_comb begin
        w_alu_out = w_alu_b;
        case (w_aluop)
            4'd0: w_alu_out = w_alu_a + w_alu_b;
            4'd1: w_alu_out = w_alu_a - w_alu_b;
            4'd2: w_alu_out = w_alu_a & w_alu_b;
            4'd3: w_alu_out = w_alu_a | w_alu_b;
            4'd4: w_alu_out = w_alu_a ^ w_alu_b;
            4'd5: w_alu_out = w_alu_a << w_alu_b[4:0];
            4'd6: w_alu_out = w_alu_a >> w_alu_b[4:0];
            4'd7: w_alu_out = $signed(w_alu_a) >>> w_alu_b[4:0];
            4'd8: w_alu_out = {31'd0, ($signed(w_alu_a) < $signed(w_alu_b))};
            4'd9: w_alu_out = {31'd0, (w_alu_a < w_alu_b)};
            default: w_alu_out = w_alu_b;
        endcase
    end

    // Next-state, bus and register-write decisions for the four-state sequencer.
    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_ir_next        = r_ir;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_retire_next    = 1'b0;
        w_rf_we          = 1'b0;
        w_rf_waddr       = w_rd;
        w_rf_wdata       = w_alu_out;
        case (r_state)
            FETCH: begin
                if (!r_mem_req) begin
                    w_mem_req_next  = 1'b1;
                    w_mem_we_next   = 1'b0;
                    w_mem_addr_next = r_pc;
                end else if (mem_ready) begin
                    w_ir_next      = mem_rdata;
                    w_mem_req_next = 1'b0;
                    w_state_next   = EXEC;
                end
            end
            EXEC: begin
                w_retire_next = 1'b1;
                w_state_next  = FETCH;
                w_pc_next     = w_pc_inc;
                case (w_form)
                    2'b00, 2'b01: begin
                        if (r_ir[29:28] == 2'b01) begin
                            w_mem_addr_next = w_alu_out[ADDR_W-1:0];
                            w_retire_next   = 1'b0;
                            w_pc_next       = r_pc;
                            w_state_next    = LOAD;
                        end else if (r_ir[29:28] == 2'b10) begin
                            w_mem_addr_next  = w_alu_out[ADDR_W-1:0];
                            w_mem_wdata_next = w_rd_val;
                            w_retire_next    = 1'b0;
                            w_pc_next        = r_pc;
                            w_state_next     = STORE;
                        end else begin
                            w_rf_we = 1'b1;
                        end
                    end
                    2'b10: begin
                        if (w_br_take) w_pc_next = w_br_target;
                        if (r_ir[28]) begin
                            w_rf_we    = 1'b1;
                            w_rf_waddr = L_LINK_REG;
                            w_rf_wdata = w_link;
                        end
                    end
                    default: begin
`ifdef CPU_TRAP_EN
                        w_rf_we    = 1'b1;
                        w_rf_waddr = L_TRAP_REG;
                        w_rf_wdata = w_link;
                        w_pc_next  = L_TRAP_VEC;
`endif
                    end
                endcase
            end
            LOAD: begin
                if (!r_mem_req) begin
                    w_mem_req_next = 1'b1;
                end else if (mem_ready) begin
                    w_rf_we        = 1'b1;
                    w_rf_wdata     = mem_rdata;
                    w_pc_next      = w_pc_inc;
                    w_mem_req_next = 1'b0;
                    w_retire_next  = 1'b1;
                    w_state_next   = FETCH;
                end
            end
            default: begin
                if (!r_mem_req) begin
                    w_mem_req_next = 1'b1;
                    w_mem_we_next  = 1'b1;
                end else if (mem_ready) begin
                    w_pc_next      = w_pc_inc;
                    w_mem_req_next = 1'b0;
                    w_mem_we_next  = 1'b0;
                    w_retire_next  = 1'b1;
                    w_state_next   = FETCH;
                end
            end
        endcase
    end

    // Architectural state and registered bus outputs; reset abandons any transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FETCH;
            r_pc        <= L_RESET_PC;
            r_ir        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_retire    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_ir        <= w_ir_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_retire    <= w_retire_next;
        end
    end

    // Register file write port, used only from EXEC or LOAD.
    always_ff @(posedge clk) begin
        if (w_rf_we) r_regs[w_rf_waddr] <= w_rf_wdata;
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign retire    = r_retire;
endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: directed program run against a memory model with a bus scoreboard
// (expected fetch/load/store transfers queued up front, checked at each handshake)
// and a per-instruction latency scoreboard driven from the retire pulses.
module tb_cpu_mc;
    localparam int ADDR_W = 30;
    localparam logic [ADDR_W-1:0] SLOW_ADDR = 30'h20;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_req, mem_we, mem_ready, retire;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;
    int slow_waits = 2;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [31:0]       wdata;
        logic              care;
    } xact_t;

    xact_t exp_q[$];
    int    lat_q[$];
    logic [31:0] mem [logic [ADDR_W-1:0]];

    cpu_mc #(.ADDR_W(ADDR_W), .REG_COUNT(16), .RESET_PC(0), .TRAP_VEC(1)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .retire(retire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [1:0] sub, input logic [3:0] rd,
                                        input logic [3:0] op, input logic [3:0] ra,
                                        input logic [15:0] imm);
        return {2'b00, sub, rd, op, ra, imm};
    endfunction

    function automatic logic [31:0] br(input logic z, input logic lnk, input logic [3:0] rd,
                                       input int off);
        logic [31:0] o;
        o = off;
        return {2'b10, z, lnk, rd, o[23:0]};
    endfunction

    task automatic push(input logic [ADDR_W-1:0] a, input logic we, input logic [31:0] d,
                        input logic care);
        xact_t e;
        e.addr = a; e.we = we; e.wdata = d; e.care = care;
        exp_q.push_back(e);
    endtask

    task automatic pf(input logic [ADDR_W-1:0] a);
        push(a, 1'b0, 32'h0, 1'b0);
    endtask

    // Memory model: slow address gets wait states, ready idles high (must be ignored),
    // held-request stability and the transfer scoreboard are checked here.
    initial begin : mem_model
        int wait_cnt;
        int ws;
        logic prev_pending;
        logic [ADDR_W-1:0] prev_addr;
        logic prev_we;
        logic [31:0] prev_wdata;
        xact_t e;
        wait_cnt = 0; prev_pending = 1'b0;
        prev_addr = '0; prev_we = 1'b0; prev_wdata = '0;
        mem_ready = 1'b1; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (prev_pending && mem_req) begin
                check("hold_addr", 32'(mem_addr), 32'(prev_addr));
                check("hold_we", 32'(mem_we), 32'(prev_we));
                check("hold_wdata", mem_wdata, prev_wdata);
            end
            if (mem_req) begin
                ws = (mem_addr == SLOW_ADDR) ? slow_waits : 0;
                if (wait_cnt < ws) begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                    prev_pending = 1'b1;
                    prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
                end else begin
                    mem_ready = 1'b1;
                    wait_cnt = 0;
                    prev_pending = 1'b0;
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    $display("xact addr=%h we=%0d wdata=%h rdata=%h", mem_addr, mem_we,
                             mem_wdata, mem_rdata);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("xact_addr", 32'(mem_addr), 32'(e.addr));
                        check("xact_we", 32'(mem_we), 32'(e.we));
                        if (e.we && e.care) check("xact_wdata", mem_wdata, e.wdata);
                    end
                end
            end else begin
                mem_ready = 1'b1;
                wait_cnt = 0;
                prev_pending = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int last_ret;
        int lat;
        bit found;
        rst = 1'b0;

        // Program image.
        mem[30'd0]  = ins(2'd0, 4'd0, 4'd15, 4'd0, 16'h0005);   // MOV R0,5
        mem[30'd1]  = ins(2'd0, 4'd4, 4'd15, 4'd0, 16'h0002);   // MOV R4,2
        mem[30'd2]  = ins(2'd0, 4'd1, 4'd0, 4'd0, 16'hFFFF);    // ADD R1,R0,-1
        mem[30'd3]  = ins(2'd2, 4'd1, 4'd0, 4'd0, 16'h000B);    // ST R1,[0x10]
        mem[30'd4]  = ins(2'd1, 4'd3, 4'd0, 4'd0, 16'h001B);    // LD R3,[0x20]
        mem[30'd5]  = ins(2'd0, 4'd4, 4'd1, 4'd4, 16'h0001);    // SUB R4,R4,1
        mem[30'd6]  = ins(2'd2, 4'd15, 4'd0, 4'd0, 16'h000D);   // ST R15,[0x12]
        mem[30'd7]  = ins(2'd0, 4'd15, 4'd15, 4'd0, 16'h0077);  // MOV R15,0x77
        mem[30'd8]  = br(1'b0, 1'b1, 4'd4, -3);                 // BNZ-link R4 -> 5
        mem[30'd9]  = ins(2'd2, 4'd15, 4'd0, 4'd0, 16'h000E);   // ST R15,[0x13]
        mem[30'd10] = ins(2'd2, 4'd3, 4'd0, 4'd0, 16'h000C);    // ST R3,[0x11]
        mem[30'd11] = br(1'b1, 1'b0, 4'd4, -12);                // BZ R4 -> top
        mem[30'h3FFFFFFF] = ins(2'd0, 4'd7, 4'd15, 4'd0, 16'h0001);
        mem[SLOW_ADDR] = 32'hDEADBEEF;

        // Expected bus trace up to the second (abandoned) load.
        pf(0); pf(1); pf(2); pf(3); push(30'h10, 1'b1, 32'h4, 1'b1);
        pf(4); push(30'h20, 1'b0, 32'h0, 1'b0);
        pf(5); pf(6); push(30'h12, 1'b1, 32'h0, 1'b0); pf(7); pf(8);
        pf(5); pf(6); push(30'h12, 1'b1, 32'h24, 1'b1); pf(7); pf(8);
        pf(9); push(30'h13, 1'b1, 32'h24, 1'b1);
        pf(10); push(30'h11, 1'b1, 32'hDEADBEEF, 1'b1);
        pf(11); pf(30'h3FFFFFFF);
        pf(0); pf(1); pf(2); pf(3); push(30'h10, 1'b1, 32'h4, 1'b1);
        pf(4); push(30'h20, 1'b0, 32'h0, 1'b0);
        lat_q = '{5, 7, 3, 5, 3, 3, 3, 5, 3, 3, 5, 5, 3, 3, 3, 3, 3, 5};

        repeat (2) @(negedge clk);
        check("rst_req", 32'(mem_req), 32'h0);
        check("rst_we", 32'(mem_we), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_retire", 32'(retire), 32'h0);
        rst = 1'b1;

        // ALU-only start: request 1 cycle in 3, retire every 3rd cycle.
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check($sformatf("req_c%0d", i), 32'(mem_req), 32'((i % 3) == 1));
            check($sformatf("ret_c%0d", i), 32'(retire), 32'((i % 3) == 0));
        end

        // Latency scoreboard until the second load is waiting.
        cyc = 9; last_ret = 9; found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge clk); #1;
            cyc++;
            if (retire) begin
                lat = cyc - last_ret;
                last_ret = cyc;
                if (lat_q.size() > 0) begin
                    check("latency", 32'(lat), 32'(lat_q.pop_front()));
                end else begin
                    check("unexpected_retire", 32'(retire), 32'h0);
                end
            end
            if (exp_q.size() == 1 && mem_req && mem_addr == SLOW_ADDR && !mem_ready)
                found = 1'b1;
        end
        check("load_wait_reached", 32'(found), 32'h1);
        check("lat_q_drained", 32'(lat_q.size()), 32'h0);

        // Asynchronous reset in the middle of a waiting load.
        rst = 1'b0;
        #1;
        check("abort_req", 32'(mem_req), 32'h0);
        check("abort_we", 32'(mem_we), 32'h0);
        check("abort_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        exp_q.delete();
        mem[30'd4] = 32'hC000_0000;
`ifdef CPU_TRAP_EN
        mem[30'd3] = ins(2'd2, 4'd14, 4'd0, 4'd0, 16'h000F);    // ST R14,[0x14]
        pf(0); pf(1); pf(2); pf(3); push(30'h14, 1'b1, 32'h0, 1'b0);
        pf(4); pf(1); pf(2); pf(3); push(30'h14, 1'b1, 32'h14, 1'b1);
`else
        pf(0); pf(1); pf(2); pf(3); push(30'h10, 1'b1, 32'h4, 1'b1);
        pf(4); pf(5);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("restart_req", 32'(mem_req), 32'h1);
        check("restart_addr", 32'(mem_addr), 32'h0);
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) found = 1'b1;
        end
        check("phase_b_drained", 32'(found), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
